// File: rtl/l2_in_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : l2_in_arbiter                                              |
// | Description : Input arbiter and peek sequencer in front of the L2        |
// |               request buffer. Picks one of four input queues (rsp, fwd,  |
// |               cpu, flush) by fixed priority, peeks the request buffer    |
// |               for one cycle, then pops and dispatches the winner or      |
// |               leaves it blocked. Owns the free-entry count and the       |
// |               set-conflict / forward-stall blocking flags.               |
// | Ports       : clk, rst (async, active-low)                               |
// |               *_valid / *_ready  : head-of-queue handshake per class     |
// |               reqs_op_code       : request-buffer opcode                 |
// |               set/clr_* inputs   : request-buffer peek results           |
// |               reqs_alloc/free    : entry fill / release events           |
// |               fwd_stall_clr,done : pipeline feedback                     |
// |               dispatch_valid,decision : dispatch pulse and class         |
// |               reqs_cnt, set_conflict, fwd_stall, fwd_stall_i : status    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module l2_in_arbiter #(
  parameter int N_REQS    = 4,
  parameter int REQS_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rsp_in_valid,
  input  logic                 fwd_in_valid,
  input  logic                 cpu_req_valid,
  input  logic                 flush_valid,
  output logic                 rsp_in_ready,
  output logic                 fwd_in_ready,
  output logic                 cpu_req_ready,
  output logic                 flush_ready,
  output logic [2:0]           reqs_op_code,
  input  logic                 set_set_conflict_reqs,
  input  logic                 clr_set_conflict_reqs,
  input  logic                 set_fwd_stall,
  input  logic                 clr_fwd_stall,
  input  logic                 set_fwd_stall_i,
  input  logic [REQS_BITS-1:0] fwd_stall_i_wr_data,
  input  logic                 reqs_alloc,
  input  logic                 reqs_free,
  input  logic                 fwd_stall_clr,
  input  logic                 done,
  output logic                 dispatch_valid,
  output logic [1:0]           decision,
  output logic [REQS_BITS:0]   reqs_cnt,
  output logic                 set_conflict,
  output logic                 fwd_stall,
  output logic [REQS_BITS-1:0] fwd_stall_i
);

  localparam logic [2:0] L2_REQS_IDLE       = 3'd0;
  localparam logic [2:0] L2_REQS_LOOKUP     = 3'd1;
  localparam logic [2:0] L2_REQS_PEEK_REQ   = 3'd2;
  localparam logic [2:0] L2_REQS_PEEK_FWD   = 3'd3;
  localparam logic [2:0] L2_REQS_PEEK_FLUSH = 3'd4;

  localparam logic [1:0] DEC_RSP   = 2'd0;
  localparam logic [1:0] DEC_FWD   = 2'd1;
  localparam logic [1:0] DEC_CPU   = 2'd2;
  localparam logic [1:0] DEC_FLUSH = 2'd3;

  localparam int                 CNT_W    = REQS_BITS + 1;
  localparam logic [REQS_BITS:0] CNT_FULL = CNT_W'(N_REQS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEEK = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t               state;
  state_t               next_state;
  logic                 elig_rsp;
  logic                 elig_fwd;
  logic                 elig_cpu;
  logic                 elig_flush;
  logic                 any_elig;
  logic [1:0]           winner;
  logic                 abort;
  logic                 capture;
  logic [REQS_BITS:0]   cnt_next;

  // Eligibility is gated by reset so the opcode stays IDLE while rst is low,
  // even if queues keep presenting valid heads.
  always_comb begin
    elig_rsp   = rst && rsp_in_valid;
    elig_fwd   = rst && fwd_in_valid && !fwd_stall;
    elig_cpu   = rst && cpu_req_valid && !set_conflict && (reqs_cnt != '0);
    elig_flush = rst && flush_valid && (reqs_cnt != '0) && !cpu_req_valid;
    any_elig   = elig_rsp || elig_fwd || elig_cpu || elig_flush;
    if (elig_rsp)      winner = DEC_RSP;
    else if (elig_fwd) winner = DEC_FWD;
    else if (elig_cpu) winner = DEC_CPU;
    else               winner = DEC_FLUSH;
  end

  // Flags sampled at the IDLE->PEEK edge already reflect this peek's result,
  // so the PEEK cycle can decide to abort from the registered values.
  assign abort   = ((decision == DEC_CPU) && set_conflict) ||
                   ((decision == DEC_FWD) && fwd_stall);
  assign capture = (state == ST_IDLE) && any_elig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    reqs_op_code   = L2_REQS_IDLE;
    dispatch_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_elig) begin
          next_state = ST_PEEK;
          case (winner)
            DEC_RSP:  reqs_op_code = L2_REQS_LOOKUP;
            DEC_FWD:  reqs_op_code = L2_REQS_PEEK_FWD;
            DEC_CPU:  reqs_op_code = L2_REQS_PEEK_REQ;
            default:  reqs_op_code = L2_REQS_PEEK_FLUSH;
          endcase
        end
      end
      ST_PEEK: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else begin
          dispatch_valid = 1'b1;
          next_state     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign rsp_in_ready  = dispatch_valid && (decision == DEC_RSP);
  assign fwd_in_ready  = dispatch_valid && (decision == DEC_FWD);
  assign cpu_req_ready = dispatch_valid && (decision == DEC_CPU);
  assign flush_ready   = dispatch_valid && (decision == DEC_FLUSH);

  // Decision and blocking flags. A set always beats a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      decision     <= DEC_RSP;
      set_conflict <= 1'b0;
      fwd_stall    <= 1'b0;
      fwd_stall_i  <= '0;
    end else begin
      if (capture) decision <= winner;

      if (capture && set_set_conflict_reqs)
        set_conflict <= 1'b1;
      else if ((capture && clr_set_conflict_reqs) || reqs_free)
        set_conflict <= 1'b0;

      if (capture && set_fwd_stall)
        fwd_stall <= 1'b1;
      else if ((capture && clr_fwd_stall) || fwd_stall_clr)
        fwd_stall <= 1'b0;

      if (capture && set_fwd_stall_i) fwd_stall_i <= fwd_stall_i_wr_data;
    end
  end

  // Free-entry counter saturates at both ends; alloc+free together cancel.
  always_comb begin
    cnt_next = reqs_cnt;
    if (reqs_alloc && !reqs_free && (reqs_cnt != '0))
      cnt_next = reqs_cnt - 1'b1;
    else if (reqs_free && !reqs_alloc && (reqs_cnt != CNT_FULL))
      cnt_next = reqs_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqs_cnt <= CNT_FULL;
    end else begin
      reqs_cnt <= cnt_next;
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(reqs_alloc && !reqs_free && (reqs_cnt == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(reqs_free && !reqs_alloc && (reqs_cnt == CNT_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_l2_in_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_l2_in_arbiter                                           |
// | Description : Self-checking bench for l2_in_arbiter. Expected dispatch   |
// |               classes are queued when a peek is launched and compared    |
// |               against each dispatch pulse.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_l2_in_arbiter;

  localparam logic [2:0] OP_IDLE   = 3'd0;
  localparam logic [2:0] OP_LOOKUP = 3'd1;
  localparam logic [2:0] OP_REQ    = 3'd2;
  localparam logic [2:0] OP_FWD    = 3'd3;
  localparam logic [2:0] OP_FLUSH  = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rsp_in_valid, fwd_in_valid, cpu_req_valid, flush_valid;
  logic       rsp_in_ready, fwd_in_ready, cpu_req_ready, flush_ready;
  logic [2:0] reqs_op_code;
  logic       set_set_conflict_reqs, clr_set_conflict_reqs;
  logic       set_fwd_stall, clr_fwd_stall, set_fwd_stall_i;
  logic [1:0] fwd_stall_i_wr_data;
  logic       reqs_alloc, reqs_free, fwd_stall_clr, done;
  logic       dispatch_valid;
  logic [1:0] decision;
  logic [2:0] reqs_cnt;
  logic       set_conflict, fwd_stall;
  logic [1:0] fwd_stall_i;

  int total = 0;
  int bad   = 0;
  int sb[$];
  int exp_dec;

  l2_in_arbiter #(.N_REQS(4), .REQS_BITS(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rsp_in_valid          (rsp_in_valid),
    .fwd_in_valid          (fwd_in_valid),
    .cpu_req_valid         (cpu_req_valid),
    .flush_valid           (flush_valid),
    .rsp_in_ready          (rsp_in_ready),
    .fwd_in_ready          (fwd_in_ready),
    .cpu_req_ready         (cpu_req_ready),
    .flush_ready           (flush_ready),
    .reqs_op_code          (reqs_op_code),
    .set_set_conflict_reqs (set_set_conflict_reqs),
    .clr_set_conflict_reqs (clr_set_conflict_reqs),
    .set_fwd_stall         (set_fwd_stall),
    .clr_fwd_stall         (clr_fwd_stall),
    .set_fwd_stall_i       (set_fwd_stall_i),
    .fwd_stall_i_wr_data   (fwd_stall_i_wr_data),
    .reqs_alloc            (reqs_alloc),
    .reqs_free             (reqs_free),
    .fwd_stall_clr         (fwd_stall_clr),
    .done                  (done),
    .dispatch_valid        (dispatch_valid),
    .decision              (decision),
    .reqs_cnt              (reqs_cnt),
    .set_conflict          (set_conflict),
    .fwd_stall             (fwd_stall),
    .fwd_stall_i           (fwd_stall_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for an opcode; called at a negedge.
  task automatic wait_op(input string tag, input logic [2:0] op, input int max_cyc);
    int n;
    n = 0;
    while (reqs_op_code !== op && n < max_cyc) begin
      cyc();
      @(negedge clk);
      n++;
    end
    check(tag, reqs_op_code, op);
  endtask

  // Dispatch cycle, then one BUSY cycle in which the popped head leaves the
  // queue and done returns; ends at the start of the next IDLE cycle.
  task automatic dispatch_retire(input int cls);
    cyc();
    @(negedge clk);
    cyc();
    case (cls)
      0:       rsp_in_valid  = 1'b0;
      1:       fwd_in_valid  = 1'b0;
      2:       cpu_req_valid = 1'b0;
      default: flush_valid   = 1'b0;
    endcase
    done = 1'b1;
    @(negedge clk);
    check("busy_op", reqs_op_code, OP_IDLE);
    cyc();
    done = 1'b0;
  endtask

  // Scoreboard: every dispatch must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (dispatch_valid) begin
        if (sb.size() == 0) begin
          check("dispatch_unexpected", dispatch_valid, 1'b0);
        end else begin
          exp_dec = sb.pop_front();
          check("dispatch_dec", decision, exp_dec);
          check("dispatch_ready", {flush_ready, cpu_req_ready, fwd_in_ready, rsp_in_ready},
                4'b0001 << exp_dec);
        end
      end else if (rsp_in_ready || fwd_in_ready || cpu_req_ready || flush_ready) begin
        check("ready_without_dispatch",
              {flush_ready, cpu_req_ready, fwd_in_ready, rsp_in_ready}, 4'b0000);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rsp_in_valid = 0; fwd_in_valid = 0; cpu_req_valid = 0; flush_valid = 0;
    set_set_conflict_reqs = 0; clr_set_conflict_reqs = 0;
    set_fwd_stall = 0; clr_fwd_stall = 0; set_fwd_stall_i = 0; fwd_stall_i_wr_data = 0;
    reqs_alloc = 0; reqs_free = 0; fwd_stall_clr = 0; done = 0;

    // ---- reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_op", reqs_op_code, OP_IDLE);
    check("rst_ready", {flush_ready, cpu_req_ready, fwd_in_ready, rsp_in_ready}, 4'b0000);
    check("rst_disp", dispatch_valid, 1'b0);
    check("rst_dec", decision, 2'd0);
    check("rst_cnt", reqs_cnt, 3'd4);
    check("rst_sc", set_conflict, 1'b0);
    check("rst_fs", fwd_stall, 1'b0);
    check("rst_fsi", fwd_stall_i, 2'd0);
    cyc(); rst = 1'b1;
    @(negedge clk); check("idle_op", reqs_op_code, OP_IDLE);

    // ---- cpu alone: T peek, T+1 dispatch, done at T+3, arbitrate at T+4
    cyc(); cpu_req_valid = 1;
    @(negedge clk); check("cpu_op", reqs_op_code, OP_REQ); sb.push_back(2);
    cyc();
    @(negedge clk); check("cpu_ready", cpu_req_ready, 1'b1); check("cpu_dec", decision, 2'd2);
    cyc(); cpu_req_valid = 0;
    @(negedge clk); check("cpu_busy_op", reqs_op_code, OP_IDLE);
    cyc(); done = 1; rsp_in_valid = 1; fwd_in_valid = 1; cpu_req_valid = 1;
    @(negedge clk); check("busy_hold_op", reqs_op_code, OP_IDLE);

    // ---- priority rsp > fwd > cpu
    cyc(); done = 0;
    @(negedge clk); check("prio_rsp_op", reqs_op_code, OP_LOOKUP); sb.push_back(0);
    dispatch_retire(0);
    @(negedge clk); check("prio_fwd_op", reqs_op_code, OP_FWD); sb.push_back(1);
    dispatch_retire(1);
    @(negedge clk); check("prio_cpu_op", reqs_op_code, OP_REQ); sb.push_back(2);
    dispatch_retire(2);
    @(negedge clk); check("prio_end_op", reqs_op_code, OP_IDLE);

    // ---- forward stall
    cyc(); fwd_in_valid = 1; set_fwd_stall = 1; set_fwd_stall_i = 1; fwd_stall_i_wr_data = 2'd2;
    @(negedge clk); check("fs_op", reqs_op_code, OP_FWD);
    cyc(); set_fwd_stall = 0; set_fwd_stall_i = 0; fwd_stall_i_wr_data = 0;
    @(negedge clk);
    check("fs_no_pop", fwd_in_ready, 1'b0);
    check("fs_flag", fwd_stall, 1'b1);
    check("fs_index", fwd_stall_i, 2'd2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk); check("fs_no_repeek", reqs_op_code, OP_IDLE);
    end
    cyc(); fwd_stall_clr = 1;
    @(negedge clk); check("fs_clr_cycle_op", reqs_op_code, OP_IDLE);
    cyc(); fwd_stall_clr = 0;
    @(negedge clk); check("fs_cleared", fwd_stall, 1'b0);
    wait_op("fs_repeek", OP_FWD, 2); sb.push_back(1);
    dispatch_retire(1);

    // ---- set conflict (one entry allocated first so reqs_free is legal)
    reqs_alloc = 1;
    cyc(); reqs_alloc = 0;
    @(negedge clk); check("alloc1_cnt", reqs_cnt, 3'd3);
    cyc(); cpu_req_valid = 1; set_set_conflict_reqs = 1;
    @(negedge clk); check("sc_op", reqs_op_code, OP_REQ);
    cyc(); set_set_conflict_reqs = 0;
    @(negedge clk); check("sc_no_pop", cpu_req_ready, 1'b0); check("sc_flag", set_conflict, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk); check("sc_blocked", reqs_op_code, OP_IDLE);
    end
    cyc(); reqs_free = 1;
    @(negedge clk); check("sc_free_cycle_op", reqs_op_code, OP_IDLE);
    cyc(); reqs_free = 0;
    @(negedge clk); check("sc_cleared", set_conflict, 1'b0); check("sc_cnt", reqs_cnt, 3'd4);
    wait_op("sc_repeek", OP_REQ, 2); sb.push_back(2);
    dispatch_retire(2);

    // ---- full buffer
    for (int i = 0; i < 4; i++) begin
      if (i == 0) reqs_alloc = 1;
      else cyc();
    end
    cyc(); reqs_alloc = 0;
    @(negedge clk); check("full_cnt", reqs_cnt, 3'd0);
    cyc(); cpu_req_valid = 1; flush_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("full_blocks", reqs_op_code, OP_IDLE);
      cyc();
    end
    rsp_in_valid = 1;
    @(negedge clk); check("full_rsp_op", reqs_op_code, OP_LOOKUP); sb.push_back(0);
    dispatch_retire(0);
    @(negedge clk); check("full_after_rsp", reqs_op_code, OP_IDLE);
    cyc(); cpu_req_valid = 0;
    @(negedge clk); check("full_flush_blocked", reqs_op_code, OP_IDLE);
    cyc(); reqs_alloc = 1; reqs_free = 1;
    @(negedge clk); check("both_cycle_op", reqs_op_code, OP_IDLE);
    cyc(); reqs_alloc = 0; reqs_free = 0;
    @(negedge clk); check("both_cnt", reqs_cnt, 3'd0);
    cyc(); reqs_free = 1;
    cyc(); reqs_free = 0;
    @(negedge clk); check("free1_cnt", reqs_cnt, 3'd1);
    check("flush_op", reqs_op_code, OP_FLUSH); sb.push_back(3);
    dispatch_retire(3);

    // ---- reset in the middle of a peek
    cyc(); cpu_req_valid = 1;
    @(negedge clk); check("mid_op", reqs_op_code, OP_REQ);
    cyc(); rst = 1'b0;
    @(negedge clk);
    check("mid_no_ready", cpu_req_ready, 1'b0);
    check("mid_no_disp", dispatch_valid, 1'b0);
    check("mid_op_idle", reqs_op_code, OP_IDLE);
    check("mid_dec", decision, 2'd0);
    check("mid_cnt", reqs_cnt, 3'd4);
    check("mid_flags", {set_conflict, fwd_stall, fwd_stall_i}, 4'd0);
    cyc(); rst = 1'b1; cpu_req_valid = 0;
    repeat (2) cyc();
    @(negedge clk); check("post_rst_op", reqs_op_code, OP_IDLE);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
